huffman_decoder: RTL and testbench
==================================

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 The block SHALL have parameter NUM_SYMS, default 6, giving the number of code-table entries.
REQ-002 The block SHALL have parameter MAX_LEN, default 8, giving the maximum code length in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 ctrl_wrTable  in  1  table write strobe.
REQ-007 wrIndex  in  3  table entry index to write.
REQ-008 wrAscii  in  8  symbol stored in the entry.
REQ-009 wrCode  in  MAX_LEN  code bits, right-aligned, MSB first on the wire.
REQ-010 wrLen  in  4  code length; 0 marks the entry invalid.
REQ-011 ctrl_start  in  1  pulse that begins decoding.
REQ-012 ctrl_stop  in  1  pulse that ends decoding and returns to IDLE.
REQ-013 bit_in  in  1  serial code bit.
REQ-014 bit_valid  in  1  bit_in is valid.
REQ-015 bit_ready  out  1  decoder accepts bit_in this cycle.
REQ-016 sym_out  out  8  decoded symbol.
REQ-017 sym_valid  out  1  sym_out is valid.
REQ-018 sym_ready  in  1  downstream accepts sym_out.
REQ-019 busy  out  1  high whenever the state is not IDLE.
REQ-020 err  out  1  sticky flag for an undecodable stream.

Function
REQ-021 States SHALL be IDLE, RUN and ERR.
REQ-022 In IDLE, ctrl_wrTable with wrIndex<NUM_SYMS SHALL write {wrAscii, wrCode, wrLen} to that entry on the same edge; a wrIndex>=NUM_SYMS write SHALL be ignored.
REQ-023 Table writes outside IDLE SHALL be ignored.
REQ-024 IDLE->RUN on ctrl_start; the bit accumulator and bit count SHALL clear on entry.
REQ-025 bit_ready SHALL be (state==RUN) && (!sym_valid || sym_ready).
REQ-026 Each accepted bit (bit_valid && bit_ready) SHALL shift into the accumulator: acc={acc,bit_in}, count+1.
REQ-027 The new accumulator SHALL be compared with every valid entry where wrLen==count+1 and the low bits of the code are equal.
REQ-028 On a match, sym_out SHALL load the matching symbol and sym_valid SHALL assert on the next edge (1-cycle latency); acc and count SHALL clear.
REQ-029 Ambiguous tables SHALL resolve to the lowest matching index.
REQ-030 The output SHALL be a one-entry buffer: sym_valid holds with sym_out stable until sym_ready; a same-cycle accept plus new match reloads it without a bubble.
REQ-031 If count reaches MAX_LEN with no match: RUN->ERR, err=1, bit_ready=0, any pending sym_valid is still delivered.
REQ-032 ERR SHALL be left only by reset.
REQ-033 ctrl_stop in RUN SHALL go to IDLE, discard the partial code and drop a pending sym_valid.
REQ-034 ctrl_start outside IDLE SHALL be ignored.
REQ-035 ctrl_stop and ctrl_start asserted together in IDLE: start SHALL win.

Reset
REQ-036 Reset SHALL force IDLE, set all table entries invalid (len=0), clear acc, count, sym_out=0, sym_valid=0, err=0, busy=0, bit_ready=0.
REQ-037 Reset mid-RUN SHALL abort immediately with no further sym_valid.

Configuration
REQ-038 With macro HUFF_DEC_COUNT_EN defined, the block SHALL add output sym_count[15:0]: +1 per sym_valid&&sym_ready handshake, saturating at 0xFFFF, cleared by reset and on ctrl_start.
REQ-039 Without HUFF_DEC_COUNT_EN, the sym_count port and counter SHALL be absent.

Verification
REQ-040 Load 0x41='0'/1, 0x42='10'/2, 0x43='110'/3, 0x44='1110'/4, 0x45='11110'/5, 0x46='11111'/5; start; stream 0,1,0,1,1,0 with sym_ready=1 -> 0x41, 0x42, 0x43, each sym_valid one cycle after the final code bit.
REQ-041 Same table; hold sym_ready=0 after the first symbol -> sym_out=0x41 stable, bit_ready=0 until sym_ready=1.
REQ-042 Table with only 0x41='0'/1; stream 8 ones (MAX_LEN=8) -> err=1 after the 8th bit, bit_ready=0, busy=1.
REQ-043 Pulse reset mid-code (after bits 1,1) -> next cycle busy=0, sym_valid=0, err=0, table invalid.
REQ-044 Write with wrIndex=6 and a write during RUN -> table contents unchanged.
REQ-045 With HUFF_DEC_COUNT_EN, decode 3 symbols -> sym_count=3; ctrl_stop then ctrl_start -> sym_count=0.

Source files
------------

// File: rtl/huffman_decoder.sv
// Serial prefix-code decoder: loadable code table, bit-serial input, one-entry symbol output buffer.
// Optional macro HUFF_DEC_COUNT_EN adds a saturating delivered-symbol counter on port sym_count.
module huffman_decoder #(
    parameter int NUM_SYMS = 6,
    parameter int MAX_LEN  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ctrl_wrTable,
    input  logic [2:0]         wrIndex,
    input  logic [7:0]         wrAscii,
    input  logic [MAX_LEN-1:0] wrCode,
    input  logic [3:0]         wrLen,
    input  logic               ctrl_start,
    input  logic               ctrl_stop,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [7:0]         sym_out,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               busy,
`ifdef HUFF_DEC_COUNT_EN
    output logic [15:0]        sym_count,
`endif
    output logic               err
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} stateT;

    stateT              state;
    logic [7:0]         tblAscii [NUM_SYMS];
    logic [MAX_LEN-1:0] tblCode  [NUM_SYMS];
    logic [3:0]         tblLen   [NUM_SYMS];
    logic [MAX_LEN-1:0] acc;
    logic [3:0]         count;

    logic [MAX_LEN-1:0] newAcc;
    logic [3:0]         newCount;
    logic [MAX_LEN-1:0] lenMask;
    logic               found;
    logic [7:0]         matchAscii;
    logic               bitAccept;
    logic               symTaken;
    logic               hitMax;
    logic               wrInRange;

    assign busy      = (state != IDLE);
    assign bit_ready = (state == RUN) && (!sym_valid || sym_ready);
    assign bitAccept = bit_valid && bit_ready;
    assign symTaken  = sym_valid && sym_ready;
    assign newAcc    = {acc[MAX_LEN-2:0], bit_in};
    assign newCount  = count + 4'd1;
    assign hitMax    = (newCount == 4'(MAX_LEN));
    assign wrInRange = (32'(wrIndex) < unsigned'(NUM_SYMS));

    // Lowest matching index wins when the table is ambiguous.
    always_comb begin
        lenMask    = '0;
        found      = 1'b0;
        matchAscii = '0;
        for (int unsigned b = 0; b < unsigned'(MAX_LEN); b++) begin
            lenMask[b] = (b < 32'(newCount));
        end
        for (int unsigned i = 0; i < unsigned'(NUM_SYMS); i++) begin
            if (!found && tblLen[i] != 4'd0 && tblLen[i] == newCount &&
                ((tblCode[i] ^ newAcc) & lenMask) == '0) begin
                found      = 1'b1;
                matchAscii = tblAscii[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sym_out   <= '0;
            sym_valid <= 1'b0;
            err       <= 1'b0;
`ifdef HUFF_DEC_COUNT_EN
            sym_count <= '0;
`endif
            for (int unsigned i = 0; i < unsigned'(NUM_SYMS); i++) begin
                tblAscii[i] <= '0;
                tblCode[i]  <= '0;
                tblLen[i]   <= '0;
            end
        end else begin
`ifdef HUFF_DEC_COUNT_EN
            if (symTaken && sym_count != '1) begin
                sym_count <= sym_count + 16'd1;
            end
`endif
            case (state)
                IDLE: begin
                    if (ctrl_wrTable && wrInRange) begin
                        tblAscii[wrIndex] <= wrAscii;
                        tblCode[wrIndex]  <= wrCode;
                        tblLen[wrIndex]   <= wrLen;
                    end
                    if (ctrl_start) begin
                        state <= RUN;
                        acc   <= '0;
                        count <= '0;
`ifdef HUFF_DEC_COUNT_EN
                        sym_count <= '0;
`endif
                    end
                end
                RUN: begin
                    if (ctrl_stop) begin
                        state     <= IDLE;
                        acc       <= '0;
                        count     <= '0;
                        sym_valid <= 1'b0;
                    end else begin
                        if (symTaken) begin
                            sym_valid <= 1'b0;
                        end
                        // A match in the same cycle as a handshake reloads the buffer with no bubble.
                        if (bitAccept) begin
                            if (found) begin
                                sym_out   <= matchAscii;
                                sym_valid <= 1'b1;
                                acc       <= '0;
                                count     <= '0;
                            end else if (hitMax) begin
                                state <= ERR;
                                err   <= 1'b1;
                                acc   <= '0;
                                count <= '0;
                            end else begin
                                acc   <= newAcc;
                                count <= newCount;
                            end
                        end
                    end
                end
                ERR: begin
                    if (symTaken) begin
                        sym_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder; define HUFF_DEC_COUNT_EN to also check sym_count.
module tb_huffman_decoder;

    logic       clk;
    logic       reset;
    logic       ctrl_wrTable;
    logic [2:0] wrIndex;
    logic [7:0] wrAscii;
    logic [7:0] wrCode;
    logic [3:0] wrLen;
    logic       ctrl_start;
    logic       ctrl_stop;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [7:0] sym_out;
    logic       sym_valid;
    logic       sym_ready;
    logic       busy;
    logic       err;
`ifdef HUFF_DEC_COUNT_EN
    logic [15:0] sym_count;
`endif

    int checks   = 0;
    int failures = 0;

    huffman_decoder #(.NUM_SYMS(6), .MAX_LEN(8)) dut (
        .clk(clk),
        .reset(reset),
        .ctrl_wrTable(ctrl_wrTable),
        .wrIndex(wrIndex),
        .wrAscii(wrAscii),
        .wrCode(wrCode),
        .wrLen(wrLen),
        .ctrl_start(ctrl_start),
        .ctrl_stop(ctrl_stop),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .sym_out(sym_out),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .busy(busy),
`ifdef HUFF_DEC_COUNT_EN
        .sym_count(sym_count),
`endif
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        ctrl_wrTable = 0; ctrl_start = 0; ctrl_stop = 0;
        bit_in = 0; bit_valid = 0; sym_ready = 1;
        wrIndex = 0; wrAscii = 0; wrCode = 0; wrLen = 0;
        reset = 1;
        tick;
        tick;
        reset = 0;
    endtask

    task automatic writeEntry(input logic [2:0] idx, input logic [7:0] a,
                              input logic [7:0] c, input logic [3:0] l);
        ctrl_wrTable = 1; wrIndex = idx; wrAscii = a; wrCode = c; wrLen = l;
        tick;
        ctrl_wrTable = 0;
    endtask

    task automatic loadFull;
        writeEntry(3'd0, 8'h41, 8'b0,     4'd1);
        writeEntry(3'd1, 8'h42, 8'b10,    4'd2);
        writeEntry(3'd2, 8'h43, 8'b110,   4'd3);
        writeEntry(3'd3, 8'h44, 8'b1110,  4'd4);
        writeEntry(3'd4, 8'h45, 8'b11110, 4'd5);
        writeEntry(3'd5, 8'h46, 8'b11111, 4'd5);
    endtask

    task automatic pulseStart;
        ctrl_start = 1;
        tick;
        ctrl_start = 0;
    endtask

    task automatic sendBit(input logic b);
        bit_in = b; bit_valid = 1;
        tick;
        bit_valid = 0;
    endtask

    task automatic test_reset;
        doReset;
        checks++; if (sym_valid !== 1'b0) begin failures++; $display("FAIL reset_sym_valid got=%b exp=0", sym_valid); end
        checks++; if (sym_out !== 8'h00) begin failures++; $display("FAIL reset_sym_out got=%h exp=00", sym_out); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bit_ready !== 1'b0) begin failures++; $display("FAIL reset_bit_ready got=%b exp=0", bit_ready); end
        pulseStart;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
    endtask

    task automatic test_decode;
        logic       bitsV [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       expV  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] expS  [6] = '{8'h41, 8'h00, 8'h42, 8'h00, 8'h00, 8'h43};
        doReset;
        loadFull;
        pulseStart;
        for (int i = 0; i < 6; i++) begin
            bit_in = bitsV[i]; bit_valid = 1;
            tick;
            checks++; if (sym_valid !== expV[i]) begin failures++; $display("FAIL decode_valid[%0d] got=%b exp=%b", i, sym_valid, expV[i]); end
            if (expV[i]) begin
                checks++; if (sym_out !== expS[i]) begin failures++; $display("FAIL decode_sym[%0d] got=%h exp=%h", i, sym_out, expS[i]); end
            end
        end
        bit_valid = 0;
    endtask

    task automatic test_back_to_back;
        doReset;
        loadFull;
        pulseStart;
        bit_in = 0; bit_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (sym_valid !== 1'b1 || sym_out !== 8'h41) begin failures++; $display("FAIL b2b[%0d] got valid=%b sym=%h exp valid=1 sym=41", i, sym_valid, sym_out); end
        end
        bit_valid = 0;
    endtask

    task automatic test_backpressure;
        doReset;
        loadFull;
        pulseStart;
        sym_ready = 0;
        sendBit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_out !== 8'h41) begin failures++; $display("FAIL bp_first got valid=%b sym=%h exp valid=1 sym=41", sym_valid, sym_out); end
        bit_in = 1; bit_valid = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bit_ready !== 1'b0) begin failures++; $display("FAIL bp_bit_ready[%0d] got=%b exp=0", i, bit_ready); end
            tick;
            checks++; if (sym_valid !== 1'b1 || sym_out !== 8'h41) begin failures++; $display("FAIL bp_hold[%0d] got valid=%b sym=%h exp valid=1 sym=41", i, sym_valid, sym_out); end
        end
        sym_ready = 1;
        #1;
        checks++; if (bit_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bit_ready); end
        tick;
        checks++; if (sym_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", sym_valid); end
        bit_in = 0;
        tick;
        bit_valid = 0;
        checks++; if (sym_valid !== 1'b1 || sym_out !== 8'h42) begin failures++; $display("FAIL bp_second got valid=%b sym=%h exp valid=1 sym=42", sym_valid, sym_out); end
    endtask

    task automatic test_error;
        doReset;
        writeEntry(3'd0, 8'h41, 8'b0, 4'd1);
        pulseStart;
        bit_in = 1; bit_valid = 1;
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++; if (err !== (i == 7)) begin failures++; $display("FAIL err_bit[%0d] got=%b exp=%b", i, err, (i == 7)); end
        end
        checks++; if (bit_ready !== 1'b0) begin failures++; $display("FAIL err_bit_ready got=%b exp=0", bit_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL err_busy got=%b exp=1", busy); end
        bit_valid = 0;
        ctrl_stop = 1;
        tick;
        ctrl_stop = 0;
        pulseStart;
        checks++; if (busy !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL err_sticky got busy=%b err=%b exp busy=1 err=1", busy, err); end
    endtask

    task automatic test_reset_mid;
        doReset;
        loadFull;
        pulseStart;
        sendBit(1'b1);
        sendBit(1'b1);
        reset = 1;
        tick;
        reset = 0;
        checks++; if (busy !== 1'b0 || sym_valid !== 1'b0 || err !== 1'b0 || bit_ready !== 1'b0)
            begin failures++; $display("FAIL rstmid_state got busy=%b valid=%b err=%b ready=%b exp all 0", busy, sym_valid, err, bit_ready); end
        pulseStart;
        bit_in = 0; bit_valid = 1;
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++; if (sym_valid !== 1'b0) begin failures++; $display("FAIL rstmid_table_invalid[%0d] got valid=%b exp=0", i, sym_valid); end
        end
        bit_valid = 0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rstmid_err got=%b exp=1", err); end
    endtask

    task automatic test_table_guard;
        doReset;
        loadFull;
        writeEntry(3'd6, 8'h5A, 8'b1, 4'd1);
        writeEntry(3'd7, 8'h5B, 8'b1, 4'd1);
        pulseStart;
        writeEntry(3'd0, 8'h5C, 8'b0, 4'd1);
        writeEntry(3'd1, 8'h5D, 8'b1, 4'd1);
        sendBit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_out !== 8'h41) begin failures++; $display("FAIL guard_idx0 got valid=%b sym=%h exp valid=1 sym=41", sym_valid, sym_out); end
        sendBit(1'b1);
        checks++; if (sym_valid !== 1'b0) begin failures++; $display("FAIL guard_one_bit got valid=%b exp=0", sym_valid); end
        sendBit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_out !== 8'h42) begin failures++; $display("FAIL guard_idx1 got valid=%b sym=%h exp valid=1 sym=42", sym_valid, sym_out); end
    endtask

    task automatic test_stop;
        doReset;
        loadFull;
        pulseStart;
        sym_ready = 0;
        sendBit(1'b0);
        ctrl_stop = 1;
        tick;
        ctrl_stop = 0;
        checks++; if (sym_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_drop got valid=%b busy=%b exp 0 0", sym_valid, busy); end
        sym_ready = 1;
        pulseStart;
        sendBit(1'b1);
        sendBit(1'b1);
        ctrl_stop = 1;
        tick;
        ctrl_start = 1;
        tick;
        ctrl_start = 0; ctrl_stop = 0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_wins got busy=%b exp=1", busy); end
        sendBit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_out !== 8'h41) begin failures++; $display("FAIL stop_discard got valid=%b sym=%h exp valid=1 sym=41", sym_valid, sym_out); end
    endtask

`ifdef HUFF_DEC_COUNT_EN
    task automatic test_count;
        logic bitsV [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        doReset;
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL count_reset got=%0d exp=0", sym_count); end
        loadFull;
        pulseStart;
        for (int i = 0; i < 6; i++) sendBit(bitsV[i]);
        tick;
        checks++; if (sym_count !== 16'd3) begin failures++; $display("FAIL count_three got=%0d exp=3", sym_count); end
        ctrl_stop = 1;
        tick;
        ctrl_stop = 0;
        checks++; if (sym_count !== 16'd3) begin failures++; $display("FAIL count_after_stop got=%0d exp=3", sym_count); end
        pulseStart;
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL count_start_clear got=%0d exp=0", sym_count); end
    endtask
`endif

    initial begin
        reset = 1;
        test_reset;
        test_decode;
        test_back_to_back;
        test_backpressure;
        test_error;
        test_reset_mid;
        test_table_guard;
        test_stop;
`ifdef HUFF_DEC_COUNT_EN
        test_count;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
